// File: rtl/pll_sup_pkg.sv
// Shared state encoding and default timing constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAILED
  } sup_state_t;

  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, retries lock with a bounded timeout, and releases
// the system reset only once lock has been continuously stable.
//
// state     | meaning
// PLL_RESET | pll_rst pulse in progress
// WAIT_LOCK | PLL released, waiting for lock or timeout
// STABILIZE | lock seen, counting consecutive locked cycles
// RUN       | system reset released, monitoring for lock loss
// FAILED    | retries exhausted, held until rst or restart
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked_in,
  input  logic               restart,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count,
  output logic               lock_lost
);

  localparam int CNT_W =
    $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  sup_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             lock_sync;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked_in),
    .q   (lock_sync)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= PLL_RESET;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      // restart wins over everything, including a coincident lock loss
      if (restart) begin
        state       <= PLL_RESET;
        cnt         <= '0;
        retry_count <= '0;
        fail        <= 1'b0;
        pll_rst     <= 1'b1;
        sys_rst     <= 1'b1;
        ready       <= 1'b0;
      end else begin
        case (state)
          PLL_RESET: begin
            if (cnt == RST_LAST) begin
              state   <= WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (lock_sync) begin
              state <= STABILIZE;
              cnt   <= '0;
            end else if (cnt == TIMEOUT_LAST) begin
              cnt <= '0;
              if (retry_count == RETRY_MAX) begin
                state <= FAILED;
                fail  <= 1'b1;
              end else begin
                state       <= PLL_RESET;
                retry_count <= retry_count + 1'b1;
                pll_rst     <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STABILIZE: begin
            if (!lock_sync) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == STABLE_LAST) begin
              state   <= RUN;
              cnt     <= '0;
              sys_rst <= 1'b0;
              ready   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            if (!lock_sync) begin
              state       <= PLL_RESET;
              cnt         <= '0;
              retry_count <= '0;
              lock_lost   <= 1'b1;
              pll_rst     <= 1'b1;
              sys_rst     <= 1'b1;
              ready       <= 1'b0;
            end
          end
          FAILED: ;
          default: begin
            state       <= PLL_RESET;
            cnt         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed latency scenarios plus random lock
// activity, all compared cycle by cycle against a timeline model of the sequence.
module tb_pll_lock_supervisor;

  localparam int SYNC    = 2;
  localparam int PULSE   = 4;
  localparam int TIMEOUT = 20;
  localparam int STABLE  = 8;
  localparam int RETRIES = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       locked_in = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst, ready, fail, lock_lost;
  logic [1:0] retry_count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  pll_lock_supervisor #(
    .SYNC_STAGES(SYNC), .RST_PULSE_CYCLES(PULSE), .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .LOCK_STABLE_CYCLES(STABLE), .MAX_RETRIES(RETRIES)
  ) dut (
    .refclk(refclk), .rst(rst), .locked_in(locked_in), .restart(restart),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
    .retry_count(retry_count), .lock_lost(lock_lost)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: phases with elapsed-time counters, fed by the lock level
  // as it was sampled SYNC edges earlier.
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_DEAD = 4;
  int   m_phase = PH_PULSE;
  int   m_elapsed = 0;
  int   m_tries = 0;
  bit   m_fail = 1'b0;
  bit   m_lost = 1'b0;
  logic samp [0:SYNC];
  logic seen;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_phase = PH_PULSE; m_elapsed = 0; m_tries = 0; m_fail = 0; m_lost = 0;
      for (int i = 0; i <= SYNC; i++) samp[i] = 1'b0;
    end else begin
      for (int i = SYNC; i > 0; i--) samp[i] = samp[i-1];
      samp[0] = locked_in;
      seen = samp[SYNC];
      m_lost = 0;
      if (restart) begin
        m_phase = PH_PULSE; m_elapsed = 0; m_tries = 0; m_fail = 0;
      end else begin
        case (m_phase)
          PH_PULSE: begin
            m_elapsed++;
            if (m_elapsed == PULSE) begin m_phase = PH_WAIT; m_elapsed = 0; end
          end
          PH_WAIT: begin
            if (seen) begin
              m_phase = PH_STAB; m_elapsed = 0;
            end else begin
              m_elapsed++;
              if (m_elapsed == TIMEOUT) begin
                m_elapsed = 0;
                if (m_tries == RETRIES) begin m_phase = PH_DEAD; m_fail = 1; end
                else begin m_tries++; m_phase = PH_PULSE; end
              end
            end
          end
          PH_STAB: begin
            if (!seen) begin
              m_phase = PH_WAIT; m_elapsed = 0;
            end else begin
              m_elapsed++;
              if (m_elapsed == STABLE) begin m_phase = PH_RUN; m_elapsed = 0; end
            end
          end
          PH_RUN: begin
            if (!seen) begin m_lost = 1; m_tries = 0; m_phase = PH_PULSE; m_elapsed = 0; end
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] model_vec();
    logic [1:0] t;
    t = m_tries[1:0];
    return {25'd0, m_phase == PH_PULSE, m_phase != PH_RUN, m_phase == PH_RUN,
            m_fail, m_lost, t};
  endfunction

  always @(negedge refclk)
    if (chk_en)
      check("cycle", {25'd0, pll_rst, sys_rst, ready, fail, lock_lost, retry_count},
            model_vec());

  task automatic wait_ready(output int n);
    n = 0;
    do begin @(negedge refclk); n++; end while (!ready && n < 200);
  endtask

  task automatic pll_rst_width(output int w);
    w = 0;
    while (pll_rst && w < 50) begin w++; @(negedge refclk); end
  endtask

  initial begin
    int n, w, pulses, lost_seen;
    bit prev;

    #1 rst = 1'b1;
    repeat (2) @(negedge refclk);
    chk_en = 1'b1;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst", sys_rst, 1);
    check("rst_ready", ready, 0);
    check("rst_retry", retry_count, 0);
    rst = 1'b0;

    // nominal lock
    repeat (3) @(negedge refclk);
    check("t1_pll_rst_hi", pll_rst, 1);
    @(negedge refclk);
    check("t1_pll_rst_lo", pll_rst, 0);
    repeat (6) @(negedge refclk);
    locked_in = 1'b1;
    wait_ready(n);
    check("t1_lock_latency", n, SYNC + 1 + STABLE);
    check("t1_sys_rst", sys_rst, 0);
    check("t1_retry", retry_count, 0);

    // lock loss in RUN
    repeat ($urandom_range(1, 10)) @(negedge refclk);
    locked_in = 1'b0;
    n = 0;
    do begin @(negedge refclk); n++; end while (!lock_lost && n < 50);
    check("t4_lost_latency", n, SYNC + 1);
    check("t4_sys_rst", sys_rst, 1);
    check("t4_ready", ready, 0);
    check("t4_retry", retry_count, 0);
    @(negedge refclk);
    check("t4_lost_once", lock_lost, 0);
    pll_rst_width(w);
    check("t4_pll_rst_width", w + 1, PULSE);

    // glitch during STABILIZE
    repeat ($urandom_range(0, 5)) @(negedge refclk);
    locked_in = 1'b1;
    repeat ($urandom_range(3, 8)) @(negedge refclk);
    locked_in = 1'b0;
    @(negedge refclk);
    locked_in = 1'b1;
    wait_ready(n);
    check("t3_glitch_latency", n, SYNC + 1 + STABLE);
    check("t3_retry", retry_count, 0);

    // never lock
    locked_in = 1'b0;
    #2 rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
    n = 0; pulses = 0; prev = 1'b0;
    do begin
      @(negedge refclk); n++;
      if (pll_rst && !prev) pulses++;
      prev = pll_rst;
    end while (!fail && n < 300);
    check("t2_fail_time", n, (RETRIES + 1) * (PULSE + TIMEOUT));
    check("t2_pulses", pulses, RETRIES + 1);
    check("t2_retry", retry_count, RETRIES);
    locked_in = 1'b1;
    repeat (10) @(negedge refclk);
    check("t2_fail_sticky", fail, 1);
    check("t2_pll_rst", pll_rst, 0);
    check("t2_sys_rst", sys_rst, 1);

    // restart in FAILED
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
    check("t5_fail_clr", fail, 0);
    check("t5_retry_clr", retry_count, 0);
    pll_rst_width(w);
    check("t5_pll_rst_width", w, PULSE);
    wait_ready(n);
    check("t5_relock", ready, 1);

    // restart coincident with lock loss
    repeat ($urandom_range(1, 6)) @(negedge refclk);
    locked_in = 1'b0;
    repeat (SYNC) @(negedge refclk);
    restart = 1'b1;
    pulses = 0; lost_seen = 0; prev = pll_rst;
    repeat (15) begin
      @(negedge refclk);
      restart = 1'b0;
      if (pll_rst && !prev) pulses++;
      if (lock_lost) lost_seen++;
      prev = pll_rst;
    end
    check("t5_no_lost", lost_seen, 0);
    check("t5_one_pulse", pulses, 1);

    // rst mid-STABILIZE
    locked_in = 1'b1;
    wait_ready(n);
    locked_in = 1'b0;
    repeat (PULSE + SYNC + 2) @(negedge refclk);
    locked_in = 1'b1;
    repeat (SYNC + 1 + 3) @(negedge refclk);
    #2 rst = 1'b1;
    #1;
    check("t6_pll_rst", pll_rst, 1);
    check("t6_sys_rst", sys_rst, 1);
    check("t6_ready", ready, 0);
    check("t6_fail", fail, 0);
    check("t6_sync_clr", dut.u_lock_sync.chain, 0);
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    wait_ready(n);
    check("t6_resume", n, PULSE + 1 + STABLE);

    // random lock activity and restarts
    for (int seg = 0; seg < 60; seg++) begin
      locked_in = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 30)) begin
        restart = ($urandom_range(0, 63) == 0);
        @(negedge refclk);
      end
      restart = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Control-side companion to the clock-generation PLL. Drives the PLL's active-high reset, monitors its asynchronous lock indication, retries lock with a bounded timeout, and releases the system reset only after lock has been continuously stable. Runs on the PLL reference clock (50 MHz), so it keeps operating while the PLL output clocks are absent.

Parameters:
SYNC_STAGES, 2, flop stages used to synchronize locked_in (minimum 2)
RST_PULSE_CYCLES, 16, width of each pll_rst pulse in refclk cycles (minimum 1)
LOCK_TIMEOUT_CYCLES, 50000, cycles to wait for lock after each pll_rst pulse (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before releasing sys_rst
MAX_RETRIES, 3, extra pll_rst attempts after the first before declaring failure

Ports:
refclk  in  1  reference clock; the only clock in the block
rst  in  1  asynchronous, active-high reset
locked_in  in  1  PLL lock indication, asynchronous to refclk
restart  in  1  synchronous one-cycle request to restart the lock sequence
pll_rst  out  1  reset to the PLL, active-high
sys_rst  out  1  system reset for logic in the PLL output domains, active-high
ready  out  1  high while in RUN
fail  out  1  sticky lock-failure flag
retry_count  out  max(1,$clog2(MAX_RETRIES+1))  retries consumed in the current sequence
lock_lost  out  1  one-cycle pulse when lock drops while in RUN

Behaviour:
- All outputs are registered. During rst: state=PLL_RESET, counter=0, sync chain=0, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_count=0, lock_lost=0.
- lock_sync is locked_in delayed through SYNC_STAGES flops. The FSM uses only lock_sync.
- Counter width is $clog2(max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)+1). The counter clears on every state change.
- PLL_RESET: pll_rst=1, sys_rst=1. Lasts exactly RST_PULSE_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - If lock_sync=1, go to STABILIZE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT_CYCLES-1: if retry_count==MAX_RETRIES, go to FAILED; else increment retry_count and go to PLL_RESET.
- STABILIZE: pll_rst=0, sys_rst=1.
  - If lock_sync=0, go to WAIT_LOCK. The timeout restarts and retry_count is unchanged.
  - After LOCK_STABLE_CYCLES consecutive cycles with lock_sync=1, go to RUN.
- RUN: sys_rst=0, ready=1.
  - If lock_sync=0: lock_lost=1 for one cycle, sys_rst=1, ready=0, retry_count=0, and go to PLL_RESET, all in the same registered update.
- FAILED: pll_rst=0, sys_rst=1, fail=1. The block stays here until rst or restart.
- restart, in any state: the next state is PLL_RESET, retry_count=0, fail=0, counter=0.
  - restart has priority over every other transition.
  - If restart coincides with lock loss in RUN, lock_lost is not pulsed.
- Latency, with cycle 0 as the first edge that samples locked_in=1 in WAIT_LOCK: state=STABILIZE at cycle SYNC_STAGES+1; ready=1 and sys_rst=0 at cycle SYNC_STAGES+1+LOCK_STABLE_CYCLES.
- Lock loss in RUN: lock_lost, sys_rst=1 and ready=0 appear SYNC_STAGES+1 cycles after the first edge that samples locked_in=0.
- rst asserted mid-operation: every output takes its reset value immediately (asynchronously). Sequencing restarts from PLL_RESET when rst is released.

Decomposition:
- Package pll_sup_pkg: state enum (PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAILED) and the default parameter constants.
- Sub-module bit_synchronizer (parameter STAGES, async active-high reset to 0) implements the locked_in synchronizer chain.

Test Plan:
All tests use SYNC_STAGES=2, RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
1. Nominal lock: release rst; locked_in=1 from cycle 10 -> pll_rst=1 for cycles 0-3; ready=1 and sys_rst=0 exactly 11 cycles after locked_in is first sampled; retry_count=0.
2. Never lock: locked_in held 0 -> pll_rst pulses 3 times; retry_count steps 0→1→2; fail=1 after 72 cycles; then pll_rst=0, sys_rst=1 held.
3. Glitch during STABILIZE: locked_in drops for 1 cycle after 5 stable cycles -> ready stays 0, retry_count unchanged; ready rises 11 cycles after locked_in is re-sampled high.
4. Lock loss in RUN: locked_in falls -> 3 cycles later lock_lost pulses once, sys_rst=1, ready=0; pll_rst=1 for 4 cycles; retry_count=0.
5. restart in FAILED -> fail=0 next cycle, pll_rst=1 for 4 cycles; restart coincident with lock loss in RUN -> lock_lost stays 0 and only one reset pulse is issued.
6. rst asserted mid-STABILIZE -> pll_rst=1, sys_rst=1, ready=0, fail=0 immediately; sync chain cleared; normal sequence resumes after release.
